uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serialises one parallel word per handshake into an asynchronous UART frame:
//   start (0), DATA_BITS LSB-first, optional parity, STOP_BITS stop (1).
//   Transmit-side companion to the UART receiver; shares its CLK_FREQUENCY,
//   BAUD_RATE and DATA_BITS so both ends of a link agree on framing.
//   Drives the board TX pin directly; idles high.
// PARAMETERS
//   CLK_FREQUENCY  100_000_000  system clock frequency, Hz
//   BAUD_RATE      115200       line bit rate, bits/s
//   DATA_BITS      8            payload bits per frame (5..9)
//   PARITY_EN      0            1 = append parity bit after data
//   PARITY_ODD     0            0 = even parity, 1 = odd (used only if PARITY_EN)
//   STOP_BITS      1            number of stop bits (1 or 2)
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   reset      in   1          synchronous, active-high reset
//   tx_data    in   DATA_BITS  word to send; sampled only on accept
//   tx_valid   in   1          tx_data is valid
//   tx_ready   out  1          block can accept a word this cycle
//   tx_serial  out  1          serial line output, idle high
//   tx_busy    out  1          a frame is in progress (not IDLE)
//   tx_done    out  1          one-cycle pulse: frame's last stop bit completed
// BEHAVIOUR
// - BAUD_DIV = CLK_FREQUENCY/BAUD_RATE (integer truncation). Every line bit is held
//   exactly BAUD_DIV clk cycles. BAUD_DIV < 2 is an elaboration error.
// - Baud counter width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1 and runs only outside IDLE.
// - Reset: state IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, counters 0.
// - Accept = tx_valid & tx_ready on a clk edge. tx_ready=1 only in IDLE.
//   tx_data is latched into a shift register on accept. Later tx_data changes are ignored.
//   tx_valid outside IDLE is ignored (no queueing).
// - FSM: IDLE -accept-> START -> DATA (DATA_BITS bits) -> PARITY (if PARITY_EN)
//   -> STOP (STOP_BITS bits) -> IDLE. Each transition happens when baud counter = BAUD_DIV-1.
// - Latency: tx_serial goes 0 on the cycle after the accept edge.
// - Data goes out LSB first; one right shift per bit period.
// - Parity = XOR of the latched data, inverted when PARITY_ODD=1.
// - Frame length F = BAUD_DIV*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
//   With the accept cycle as 0, line cycles are 1..F.
// - At cycle F+1: state is IDLE, tx_done=1 for exactly one cycle, tx_ready=1, tx_busy=0.
// - tx_busy=1 from cycle 1 through cycle F.
// - Back-to-back: tx_valid held high gives a second accept at cycle F+1.
//   Its start bit begins at F+2, so exactly one idle-high cycle separates frames.
// - tx_done and a new accept may occur in the same cycle; both are honoured.
// - Reset mid-frame: on the following cycle tx_serial=1 and state=IDLE.
//   The frame is abandoned, with no tx_done pulse. A reset edge that coincides
//   with tx_valid does not accept.
// - tx_serial is a registered output (glitch-free); no combinational path from inputs to it.
// TESTING  (CLK_FREQUENCY=50, BAUD_RATE=5 -> BAUD_DIV=10)
// - 8N1, tx_data=0xA5 accepted at cycle 0 -> tx_serial 10-cycle bits 0,1,0,1,0,0,1,0,1,1
//   over cycles 1..100; tx_done pulse at 101 only.
// - PARITY_EN=1, even, tx_data=0x07 -> parity bit 1 at cycles 91..100;
//   odd setting -> 0; stop at 101..110.
// - tx_valid held, data 0x00 then 0xFF -> second accept at 101; line high at 101;
//   second start bit 102..111.
// - Reset asserted at cycle 45 of a 0x3C frame -> tx_serial=1, tx_ready=1 at 46;
//   no tx_done; a fresh frame sends correctly.
// - tx_data changed and tx_valid pulsed at cycle 30 of frame -> ignored;
//   transmitted bits match the value latched at accept.
// - STOP_BITS=2 -> line high for cycles 91..110; tx_done at 111; tx_busy low at 111.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one parallel word per valid/ready handshake, sent as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY_EN     = 0,
  parameter int unsigned PARITY_ODD    = 0,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;

  // Frame sequencer; every line bit lasts BAUD_DIV cycles, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        baud_cnt <= '0;
        if (tx_valid && tx_ready) begin
          shift_q   <= tx_data;
          parity_q  <= (^tx_data) ^ (PARITY_ODD != 0);
          bit_cnt   <= '0;
          state     <= START;
          tx_serial <= 1'b0;
          tx_ready  <= 1'b0;
          tx_busy   <= 1'b1;
        end
      end else if (baud_cnt != BAUD_LAST) begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state     <= DATA;
            bit_cnt   <= '0;
            tx_serial <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
          DATA: begin
            if (bit_cnt != DATA_LAST) begin
              bit_cnt   <= bit_cnt + BIT_W'(1);
              tx_serial <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end else if (PARITY_EN != 0) begin
              state     <= PARITY;
              tx_serial <= parity_q;
            end else begin
              state     <= STOP;
              bit_cnt   <= '0;
              tx_serial <= 1'b1;
            end
          end
          PARITY: begin
            state     <= STOP;
            bit_cnt   <= '0;
            tx_serial <= 1'b1;
          end
          STOP: begin
            // Last stop bit done: back to idle and ready in the same cycle as the pulse.
            if (bit_cnt != STOP_LAST) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
              state     <= IDLE;
              bit_cnt   <= '0;
              tx_serial <= 1'b1;
              tx_ready  <= 1'b1;
              tx_busy   <= 1'b0;
              tx_done   <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four framing variants (8N1, 8E1, 8O1, 8N2) at BAUD_DIV=10,
// checked by a per-cycle line monitor fed from an expected-word scoreboard.
module tb_uart_tx;

  localparam int unsigned NDUT = 4;
  localparam int unsigned BD   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_valid = 4'h0;
  wire  [3:0] tx_ready, tx_serial, tx_busy, tx_done;

  int tests = 0;
  int fails = 0;

  // Expected words: {hand-computed even parity, data}
  logic [8:0] exp_q [NDUT][$];

  int         pos       [NDUT] = '{default: 0};
  int         frame_err [NDUT] = '{default: 0};
  int         first_bad [NDUT] = '{default: 0};
  int         idle_err  [NDUT] = '{default: 0};
  bit         pend      [NDUT] = '{default: 1'b0};
  logic [8:0] cur       [NDUT] = '{default: 9'h0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQUENCY(50),
      .BAUD_RATE    (5),
      .DATA_BITS    (8),
      .PARITY_EN    ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0),
      .STOP_BITS    ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .tx_serial(tx_serial[g]),
      .tx_busy  (tx_busy[g]),
      .tx_done  (tx_done[g])
    );
  end

  function automatic bit cfg_pe(int g);
    return (g == 1 || g == 2);
  endfunction

  function automatic bit cfg_po(int g);
    return (g == 2);
  endfunction

  function automatic int cfg_sb(int g);
    return (g == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(int g);
    return BD * (1 + 8 + int'(cfg_pe(g)) + cfg_sb(g));
  endfunction

  // Line value at frame cycle p (1-based) for word w on variant g.
  function automatic logic exp_bit(int g, logic [8:0] w, int p);
    int b;
    b = (p - 1) / BD;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (cfg_pe(g) && b == 9) return w[8] ^ cfg_po(g);
    return 1'b1;
  endfunction

  // Monitor: tracks each DUT's frame position and scores a frame when tx_done shows.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (reset) begin
          pos[g]  = 0;
          pend[g] = 1'b0;
        end else begin
          if (pend[g]) begin
            pos[g]  = 1;
            pend[g] = 1'b0;
          end else if (pos[g] != 0) begin
            pos[g]++;
          end
          if (pos[g] >= 1 && pos[g] <= frame_len(g)) begin
            if (tx_serial[g] !== exp_bit(g, cur[g], pos[g]) || tx_busy[g] !== 1'b1 ||
                tx_ready[g] !== 1'b0 || tx_done[g] !== 1'b0) begin
              if (frame_err[g] == 0) first_bad[g] = pos[g];
              frame_err[g]++;
            end
          end else if (pos[g] == frame_len(g) + 1) begin
            tests++;
            if (frame_err[g] != 0 || tx_done[g] !== 1'b1 || tx_ready[g] !== 1'b1 ||
                tx_busy[g] !== 1'b0 || tx_serial[g] !== 1'b1) begin
              fails++;
              $display("FAIL frame dut%0d data=%h: %0d bad line cycles (first %0d); done/ready/busy/serial=%b%b%b%b, want 1101",
                       g, cur[g][7:0], frame_err[g], first_bad[g],
                       tx_done[g], tx_ready[g], tx_busy[g], tx_serial[g]);
            end
            pos[g] = 0;
          end else begin
            if (tx_serial[g] !== 1'b1 || tx_busy[g] !== 1'b0 ||
                tx_ready[g] !== 1'b1 || tx_done[g] !== 1'b0) idle_err[g]++;
          end
          if (tx_valid[g] && tx_ready[g]) begin
            if (exp_q[g].size() == 0) begin
              idle_err[g]++;
            end else begin
              cur[g]       = exp_q[g].pop_front();
              frame_err[g] = 0;
              pend[g]      = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at frame cycle 1 (one cycle after the accept edge).
  task automatic send(int d, logic [8:0] w);
    int n;
    n = 0;
    exp_q[d].push_back(w);
    tx_data     = w[7:0];
    tx_valid[d] = 1'b1;
    while (tx_ready[d] !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    check($sformatf("accept_dut%0d", d), 32'(n < 300), 32'd1);
    step(1);
    tx_valid[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    int n;
    n = 0;
    while (tx_done[d] !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    check($sformatf("done_seen_dut%0d", d), 32'(n < 400), 32'd1);
    step(1);
  endtask

  logic [8:0] words [5] = '{
    {1'b0, 8'hA5}, {1'b1, 8'h07}, {1'b1, 8'h01}, {1'b1, 8'hC8}, {1'b0, 8'h3C}
  };

  initial begin
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    check("reset_serial", 32'(tx_serial), 32'hF);
    check("reset_ready",  32'(tx_ready),  32'hF);
    check("reset_busy",   32'(tx_busy),   32'h0);
    check("reset_done",   32'(tx_done),   32'h0);

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 5; i++) begin
        send(d, words[i]);
        wait_done(d);
      end
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF
    exp_q[0].push_back({1'b0, 8'h00});
    exp_q[0].push_back({1'b0, 8'hFF});
    tx_data     = 8'h00;
    tx_valid[0] = 1'b1;
    step(1);
    tx_data = 8'hFF;
    step(99);
    check("b2b_ready_c100", 32'(tx_ready[0]), 32'd0);
    step(1);
    check("b2b_done_c101",   32'(tx_done[0]),   32'd1);
    check("b2b_ready_c101",  32'(tx_ready[0]),  32'd1);
    check("b2b_serial_c101", 32'(tx_serial[0]), 32'd1);
    step(1);
    tx_valid[0] = 1'b0;
    check("b2b_start_c102", 32'(tx_serial[0]), 32'd0);
    check("b2b_busy_c102",  32'(tx_busy[0]),   32'd1);
    wait_done(0);

    // Reset at cycle 45 of a 0x3C frame, then a fresh frame
    send(0, {1'b0, 8'h3C});
    step(44);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_serial_c46", 32'(tx_serial[0]), 32'd1);
    check("rst_ready_c46",  32'(tx_ready[0]),  32'd1);
    check("rst_busy_c46",   32'(tx_busy[0]),   32'd0);
    step(120);
    send(0, {1'b0, 8'h3C});
    wait_done(0);

    // Data change and valid pulse mid-frame must be ignored
    send(0, {1'b0, 8'h96});
    step(29);
    tx_data     = 8'h11;
    tx_valid[0] = 1'b1;
    step(1);
    tx_valid[0] = 1'b0;
    tx_data     = 8'h00;
    wait_done(0);

    step(5);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("pending_frames_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
      check($sformatf("idle_errors_dut%0d", d),    32'(idle_err[d]),     32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
